// File: rtl/nv_clk_gate_ctrl.sv
// Idle-hysteresis clock-gate controller: gates the domain clock after a run of idle cycles and
// re-enables it with a fixed wake delay before rdy. All outputs are registered, and there is no backpressure path.
module nv_clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_vld,
  input  logic        busy,
  input  logic        force_on,
  input  logic        cnt_clr,
  output logic        clk_en,
  output logic        rdy,
  output logic [1:0]  state,
  output logic [15:0] gated_cycles
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } st_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  st_t        st_q, st_d;
  logic [7:0] idle_q, idle_d;
  logic [3:0] wake_q, wake_d;
  logic       active;

  always_comb begin
    // The pipeline is empty by construction once gated, so busy cannot wake the domain.
    active = req_vld | force_on | (busy & (st_q != ST_OFF));
    st_d   = st_q;
    idle_d = idle_q;
    wake_d = wake_q;
    case (st_q)
      ST_ON: begin
        if (!active) begin
          st_d   = ST_DRAIN;
          idle_d = 8'd0;
        end
      end
      ST_DRAIN: begin
        if (active) begin
          st_d   = ST_ON;
          idle_d = 8'd0;
        end else if (idle_q == IDLE_LAST) begin
          st_d = ST_OFF;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      ST_OFF: begin
        if (active) begin
          st_d   = ST_WAKE;
          wake_d = 4'd0;
        end
      end
      default: begin
        if (wake_q == WAKE_LAST) st_d = ST_ON;
        else                     wake_d = wake_q + 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= ST_WAKE;
      idle_q       <= 8'd0;
      wake_q       <= 4'd0;
      clk_en       <= 1'b1;
      rdy          <= 1'b0;
      gated_cycles <= 16'd0;
    end else begin
      st_q   <= st_d;
      idle_q <= idle_d;
      wake_q <= wake_d;
      // Decoded from the next state so the enable flop itself drives the gate cell.
      clk_en <= (st_d != ST_OFF);
      rdy    <= (st_d == ST_ON) || (st_d == ST_DRAIN);
      if (cnt_clr)
        gated_cycles <= 16'd0;
      else if ((st_q == ST_OFF) && (gated_cycles != 16'hFFFF))
        gated_cycles <= gated_cycles + 16'd1;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Bench for nv_clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2: directed vector table, hand sequences
// for saturation/reset corners, and randomized traffic against an idle-run/wake-countdown model.
module tb_nv_clk_gate_ctrl;
  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_vld = 1'b0;
  logic        busy = 1'b0;
  logic        force_on = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        clk_en;
  logic        rdy;
  logic [1:0]  state;
  logic [15:0] gated_cycles;

  int total = 0;
  int bad = 0;

  nv_clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .busy(busy), .force_on(force_on),
    .cnt_clr(cnt_clr), .clk_en(clk_en), .rdy(rdy), .state(state), .gated_cycles(gated_cycles)
  );

  always #5 clk = ~clk;

  // Model: domain is off, or counting down wake edges, or counting a run of idle edges.
  bit m_off = 1'b0;
  int m_wake_left = WAKE;
  int m_idle_run = 0;
  int m_gc = 0;

  function automatic int m_state();
    if (m_wake_left > 0) return 3;
    if (m_off)           return 2;
    if (m_idle_run > 0)  return 1;
    return 0;
  endfunction

  task automatic model_edge();
    bit was_off;
    was_off = m_off && (m_wake_left == 0);
    if (reset) begin
      m_off = 1'b0; m_wake_left = WAKE; m_idle_run = 0; m_gc = 0;
    end else begin
      if (cnt_clr)      m_gc = 0;
      else if (was_off) m_gc = (m_gc < 65535) ? m_gc + 1 : 65535;
      if (m_wake_left > 0) begin
        m_wake_left--;
      end else if (m_off) begin
        if (req_vld || force_on) begin
          m_off = 1'b0; m_wake_left = WAKE;
        end
      end else begin
        if (req_vld || busy || force_on) m_idle_run = 0;
        else                             m_idle_run++;
        if (m_idle_run == IDLE + 1) begin
          m_off = 1'b1; m_idle_run = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_state", int'(state), m_state());
    chk("model_clk_en", int'(clk_en), int'(!m_off));
    chk("model_rdy", int'(rdy), int'(!m_off && m_wake_left == 0));
    chk("model_gated", int'(gated_cycles), m_gc);
  endtask

  // Applies the currently driven inputs across one rising edge and compares after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic drive(input bit r, input bit q, input bit b, input bit f, input bit c);
    reset = r; req_vld = q; busy = b; force_on = f; cnt_clr = c;
  endtask

  typedef struct {
    bit          rst, req, bsy, frc, clr;
    logic [1:0]  st;
    bit          en, rd;
    logic [15:0] gc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit req, bit bsy, bit frc, bit clr,
                              int st, bit en, bit rd, int gc);
    vec_t v;
    v.rst = rst; v.req = req; v.bsy = bsy; v.frc = frc; v.clr = clr;
    v.st = 2'(st); v.en = en; v.rd = rd; v.gc = 16'(gc);
    return v;
  endfunction

  initial begin
    // reset, release into wake, drain to OFF, wake on a 1-cycle pulse
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,0, 3,1,0,0));
    vecs.push_back(mk(0,1,0,0,0, 3,1,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,1,1,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0, 1,1,1,0));
    vecs.push_back(mk(0,0,0,0,0, 2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 2,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 2,0,0,2));
    vecs.push_back(mk(0,1,0,0,0, 3,1,0,3));
    vecs.push_back(mk(0,0,0,0,0, 3,1,0,3));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1,3));
    // busy blip in DRAIN restarts the idle run
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,0, 1,1,1,3));
    vecs.push_back(mk(0,0,1,0,0, 0,1,1,3));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0, 1,1,1,3));
    vecs.push_back(mk(0,0,0,0,0, 2,0,0,3));
    // busy ignored in OFF, force_on wakes, clear during wake
    vecs.push_back(mk(0,0,1,0,0, 2,0,0,4));
    vecs.push_back(mk(0,0,0,1,0, 3,1,0,5));
    vecs.push_back(mk(0,0,0,0,1, 3,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].bsy, vecs[i].frc, vecs[i].clr);
      step();
      chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
      chk($sformatf("vec%0d_clk_en", i), int'(clk_en), int'(vecs[i].en));
      chk($sformatf("vec%0d_rdy", i), int'(rdy), int'(vecs[i].rd));
      chk($sformatf("vec%0d_gated", i), int'(gated_cycles), int'(vecs[i].gc));
    end

    // Saturation: hold OFF well past 65535 edges, then clear.
    drive(0,0,0,0,1);
    step();
    drive(0,0,0,0,0);
    for (int i = 0; i < 5; i++) step();
    chk("sat_enter_off", int'(state), 2);
    for (int i = 0; i < 66000; i++) step();
    chk("sat_value", int'(gated_cycles), 16'hFFFF);
    chk("sat_still_off", int'(clk_en), 0);
    drive(0,0,0,0,1);
    step();
    chk("clr_to_zero", int'(gated_cycles), 0);
    drive(0,0,0,0,0);
    step();
    chk("clr_then_one", int'(gated_cycles), 1);

    // Reset pulse in OFF with gated_cycles=20.
    for (int i = 0; i < 19; i++) step();
    chk("pre_reset_gated", int'(gated_cycles), 20);
    drive(1,0,0,0,0);
    step();
    chk("rst_clk_en", int'(clk_en), 1);
    chk("rst_state", int'(state), 3);
    chk("rst_gated", int'(gated_cycles), 0);
    drive(0,0,0,0,0);
    step();
    chk("rst_rdy_low", int'(rdy), 0);
    step();
    chk("rst_rdy_high", int'(rdy), 1);
    chk("rst_state_on", int'(state), 0);

    // Randomized traffic; sparse activity so gating and waking both occur.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
